// File: rtl/la_cellbist_pkg.sv
// Shared definitions for the la_cellbist standard-cell BIST sequencer:
// state encoding, MISR constants and the signature step function.
package la_cellbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [15:0] MISR_POLY = 16'h100B;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;
    localparam int          ERRCNT_W  = 8;

    // One Galois MISR shift: feedback taps folded in when the MSB falls off.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic d);
        return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ {15'b0, d};
    endfunction

endpackage

// File: rtl/la_cellbist_misr.sv
// 16-bit signature register compacting the sampled cell output.
// Only instantiated when LA_CELLBIST_MISR_EN is defined.
module la_cellbist_misr
    import la_cellbist_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic        init,
    input  logic        en,
    input  logic        d,
    output logic [15:0] sig
);

    logic [15:0] sig_q;
    logic [15:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (init) begin
            sig_d = MISR_SEED;
        end else if (en) begin
            sig_d = misr_step(sig_q, d);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sig_q <= MISR_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/la_cellbist.sv
// BIST sequencer: walks all 2^N input vectors of a combinational cell and
// checks z against TT. Optional MISR signature with LA_CELLBIST_MISR_EN.
module la_cellbist
    import la_cellbist_pkg::*;
#(
    parameter int                N      = 4,
    parameter logic [(1<<N)-1:0] TT     = 16'h007F,
    parameter int                SETTLE = 1,
    parameter                    PROP   = "DEFAULT"
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                start,
    input  logic                z,
    output logic [N-1:0]        vec,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERRCNT_W-1:0] errcnt
`ifdef LA_CELLBIST_MISR_EN
    ,
    output logic [15:0]         sig
`endif
);

    localparam int CNT_W = $clog2(SETTLE + 1);

    state_e              state_q, state_d;
    logic [N-1:0]        vec_q, vec_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
    logic                fail_q, fail_d;
    logic                start_run;
    logic                mismatch;

    assign mismatch = (z != TT[vec_q]);

    // NOTE: every always_comb output gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        errcnt_d  = errcnt_q;
        fail_d    = fail_q;
        start_run = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                start_run = start;
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    fail_d = 1'b1;
                    if (errcnt_q != {ERRCNT_W{1'b1}}) begin
                        errcnt_d = errcnt_q + 1'b1;
                    end
                end
                if (vec_q == N'((1 << N) - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                start_run = start;
            end
            default: state_d = ST_IDLE;
        endcase

        // A run request from IDLE or DONE wipes every trace of the previous run.
        if (start_run) begin
            state_d  = ST_SETTLE;
            vec_d    = '0;
            cnt_d    = '0;
            errcnt_d = '0;
            fail_d   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= ST_IDLE;
            vec_q    <= '0;
            cnt_q    <= '0;
            errcnt_q <= '0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            cnt_q    <= cnt_d;
            errcnt_q <= errcnt_d;
            fail_q   <= fail_d;
        end
    end

    assign vec    = vec_q;
    assign busy   = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done   = (state_q == ST_DONE);
    assign pass   = (state_q == ST_DONE) && !fail_q;
    assign errcnt = errcnt_q;

`ifdef LA_CELLBIST_MISR_EN
    la_cellbist_misr u_misr (
        .clk    (clk),
        .nreset (nreset),
        .init   (start_run),
        .en     (state_q == ST_SAMPLE),
        .d      (z),
        .sig    (sig)
    );
`endif

endmodule

// File: tb/tb_la_cellbist.sv
// Self-checking bench for la_cellbist driving a modelled aoi31 cell (with
// injectable faults); checks sig too when LA_CELLBIST_MISR_EN is defined.
module tb_la_cellbist;

    localparam int          N       = 4;
    localparam int          NV      = 1 << N;
    localparam int          SETTLE  = 1;
    localparam int          RUN_LEN = NV * (SETTLE + 1);
    localparam logic [15:0] TT      = 16'h007F;

    logic         clk = 1'b0;
    logic         nreset;
    logic         start;
    logic         z;
    logic [N-1:0] vec;
    logic         busy, done, pass;
    logic [7:0]   errcnt;
`ifdef LA_CELLBIST_MISR_EN
    logic [15:0]  sig;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    typedef enum {Z_GOOD, Z_ST1, Z_ST0, Z_FLIP, Z_RAND} zmode_e;

    typedef struct {
        zmode_e mode;
        int     flip;
        bit     exp_pass;
        int     exp_err;
    } vec_t;

    zmode_e        zmode    = Z_GOOD;
    int            flip_idx = 0;
    logic [NV-1:0] rand_tt  = '0;

    la_cellbist #(.N(N), .TT(TT), .SETTLE(SETTLE), .PROP("DEFAULT")) dut (
        .clk    (clk),
        .nreset (nreset),
        .start  (start),
        .z      (z),
        .vec    (vec),
        .busy   (busy),
        .done   (done),
        .pass   (pass),
        .errcnt (errcnt)
`ifdef LA_CELLBIST_MISR_EN
        ,
        .sig    (sig)
`endif
    );

    always #5 clk = ~clk;

    // aoi31 with vec = {b0,a2,a1,a0}
    function automatic logic aoi31(input int i);
        logic [3:0] v;
        v = 4'(i);
        return ~((v[0] & v[1] & v[2]) | v[3]);
    endfunction

    function automatic logic cell_z(input zmode_e m, input int f, input logic [NV-1:0] rtt, input int i);
        logic r;
        case (m)
            Z_GOOD:  r = aoi31(i);
            Z_ST1:   r = 1'b1;
            Z_ST0:   r = 1'b0;
            Z_FLIP:  r = aoi31(i) ^ (i == f);
            default: r = rtt[i];
        endcase
        return r;
    endfunction

    always_comb z = cell_z(zmode, flip_idx, rand_tt, int'(vec));

    function automatic int exp_errs(input zmode_e m, input int f, input logic [NV-1:0] rtt);
        logic [15:0] tt;
        int          e;
        tt = TT;
        e  = 0;
        for (int i = 0; i < NV; i++) begin
            if (cell_z(m, f, rtt, i) != tt[i]) e++;
        end
        return (e > 255) ? 255 : e;
    endfunction

    function automatic logic [15:0] exp_sig(input zmode_e m, input int f, input logic [NV-1:0] rtt);
        logic [15:0] s;
        s = 16'hFFFF;
        for (int i = 0; i < NV; i++) begin
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000) ^ {15'b0, cell_z(m, f, rtt, i)};
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the edge that sampled start.
    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered just after the start edge; follows the run to DONE with a cycle budget.
    task automatic track_run(input string tag, input bit exp_pass, input int exp_err, input int pulse_vec);
        int m;
        bit pulsed;
        m      = 0;
        pulsed = 1'b0;
        while (done !== 1'b1 && m < RUN_LEN + 20) begin
            if (m < RUN_LEN) begin
                check($sformatf("%s vec@%0d", tag, m), 32'(vec), 32'(m / (SETTLE + 1)));
                check($sformatf("%s busy@%0d", tag, m), 32'(busy), 32'd1);
            end
            if (!pulsed && pulse_vec >= 0 && int'(vec) == pulse_vec) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            m++;
        end
        start = 1'b0;
        check({tag, " run_len"}, 32'(m), 32'(RUN_LEN));
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_off"}, 32'(busy), 32'd0);
        check({tag, " pass"}, 32'(pass), 32'(exp_pass));
        check({tag, " errcnt"}, 32'(errcnt), 32'(exp_err));
`ifdef LA_CELLBIST_MISR_EN
        check({tag, " sig"}, 32'(sig), 32'(exp_sig(zmode, flip_idx, rand_tt)));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   e;

        tbl[0] = '{Z_GOOD, 0,  1'b1, 0};
        tbl[1] = '{Z_ST1,  0,  1'b0, 9};
        tbl[2] = '{Z_ST0,  0,  1'b0, 7};
        tbl[3] = '{Z_FLIP, 12, 1'b0, 1};
        tbl[4] = '{Z_FLIP, 0,  1'b0, 1};
        tbl[5] = '{Z_FLIP, 15, 1'b0, 1};

        // Reset, with start asserted to show reset wins.
        nreset = 1'b0;
        start  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst vec", 32'(vec), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst pass", 32'(pass), 32'd0);
        check("rst errcnt", 32'(errcnt), 32'd0);
`ifdef LA_CELLBIST_MISR_EN
        check("rst sig", 32'(sig), 32'h0000FFFF);
`endif
        start  = 1'b0;
        nreset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle hold@%0d", i), 32'({vec, busy, done, pass, errcnt}), 32'd0);
        end

        // Table-driven runs.
        for (int i = 0; i < 6; i++) begin
            zmode    = tbl[i].mode;
            flip_idx = tbl[i].flip;
            start_pulse();
            track_run($sformatf("tbl%0d", i), tbl[i].exp_pass, tbl[i].exp_err, -1);
        end

`ifdef LA_CELLBIST_MISR_EN
        check("misr flip differs", 32'(sig != exp_sig(Z_GOOD, 0, '0)), 32'd1);
`endif

        // Restart from DONE after a failing run.
        zmode = Z_ST1;
        start_pulse();
        track_run("pre_restart", 1'b0, 9, -1);
        zmode = Z_GOOD;
        start_pulse();
        check("restart done_low", 32'(done), 32'd0);
        check("restart busy", 32'(busy), 32'd1);
        check("restart errcnt_clr", 32'(errcnt), 32'd0);
        track_run("restart", 1'b1, 0, -1);

        // start pulsed mid-run at vec=3 is ignored.
        start_pulse();
        track_run("midpulse", 1'b1, 0, 3);

        // nreset mid-run at vec=5, with errors already accumulated.
        zmode = Z_ST0;
        start_pulse();
        for (int w = 0; w < RUN_LEN && vec !== 4'd5; w++) @(negedge clk);
        check("reached vec5", 32'(vec), 32'd5);
        #2;
        nreset = 1'b0;
        #1;
        check("midrst vec", 32'(vec), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst errcnt", 32'(errcnt), 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        check("midrst idle", 32'({vec, busy, done}), 32'd0);
        zmode = Z_GOOD;
        start_pulse();
        track_run("after_rst", 1'b1, 0, -1);

        // start held high: back-to-back runs with one DONE cycle between.
        zmode = Z_ST0;
        start = 1'b1;
        @(negedge clk);
        begin
            int m;
            m = 0;
            while (done !== 1'b1 && m < RUN_LEN + 20) begin
                @(negedge clk);
                m++;
            end
            check("b2b run_len", 32'(m), 32'(RUN_LEN));
            check("b2b errcnt", 32'(errcnt), 32'd7);
        end
        zmode = Z_GOOD;
        @(negedge clk);
        start = 1'b0;
        check("b2b done_one_cycle", 32'(done), 32'd0);
        check("b2b rerun busy", 32'(busy), 32'd1);
        check("b2b rerun vec", 32'(vec), 32'd0);
        check("b2b rerun errcnt", 32'(errcnt), 32'd0);
        track_run("b2b_second", 1'b1, 0, -1);

        // Random cell responses against the truth-table model.
        zmode = Z_RAND;
        for (int r = 0; r < 8; r++) begin
            rand_tt = NV'($urandom);
            e = exp_errs(Z_RAND, 0, rand_tt);
            start_pulse();
            track_run($sformatf("rand%0d", r), e == 0, e, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
